// File: rtl/dspl_fmt_ctrl_if.sv
// Status-to-display bundle between the game controller and the display formatter.
// The controller drives game status; the formatter returns busy and the eight digit codes.
interface dspl_fmt_ctrl_if;
    logic        player;
    logic [2:0]  entry_cnt;
    logic [15:0] entry_digits;
    logic        result_valid;
    logic [2:0]  bulls;
    logic [2:0]  cows;
    logic        new_game;
    logic        busy;
    logic [6:0]  d1, d2, d3, d4, d5, d6, d7, d8;

    modport master (
        output player, entry_cnt, entry_digits, result_valid, bulls, cows, new_game,
        input  busy, d1, d2, d3, d4, d5, d6, d7, d8
    );

    modport slave (
        input  player, entry_cnt, entry_digits, result_valid, bulls, cows, new_game,
        output busy, d1, d2, d3, d4, d5, d6, d7, d8
    );
endinterface

// File: rtl/dspl_fmt_ctrl.sv
// Display formatter: turns game status into eight {en, code, dp} digit codes for the
// multiplexed driver, with a timed result screen and a blinking win banner.
module dspl_fmt_ctrl #(
    parameter int unsigned MS_COUNT  = 100000,
    parameter int unsigned RESULT_MS = 2000,
    parameter int unsigned BLINK_MS  = 250
) (
    input logic            clock,
    input logic            reset,
    dspl_fmt_ctrl_if.slave bus
);
    localparam int unsigned PW     = $clog2(MS_COUNT + 1);
    localparam int unsigned MS_MAX = (RESULT_MS > BLINK_MS) ? RESULT_MS : BLINK_MS;
    localparam int unsigned MW     = $clog2(MS_MAX + 1);

    localparam logic [PW-1:0] PRESC_LAST  = PW'(MS_COUNT - 1);
    localparam logic [MW-1:0] RESULT_LAST = MW'(RESULT_MS - 1);
    localparam logic [MW-1:0] BLINK_LAST  = MW'(BLINK_MS - 1);

    localparam logic [4:0] C_1     = 5'h01;
    localparam logic [4:0] C_2     = 5'h02;
    localparam logic [4:0] C_J     = 5'h05;
    localparam logic [4:0] C_S     = 5'h06;
    localparam logic [4:0] C_E     = 5'h07;
    localparam logic [4:0] C_T     = 5'h08;
    localparam logic [4:0] C_B     = 5'h0B;
    localparam logic [4:0] C_C     = 5'h0C;
    localparam logic [4:0] C_BLANK = 5'h10;
    localparam logic [4:0] C_DASH  = 5'h11;
    localparam logic [6:0] BLANK   = 7'b0100001;

    typedef enum logic [1:0] {ST_ENTRY, ST_RESULT, ST_WIN} state_t;

    state_t          r_state, w_next_state;
    logic            w_enter, w_latch, w_tick;
    logic [PW-1:0]   r_presc;
    logic [MW-1:0]   r_ms;
    logic            r_blink_off;
    logic [2:0]      r_bulls, r_cows;
    logic            r_win_player;
    logic [2:0]      w_cnt;
    logic [7:0][6:0] w_d, r_d;

    function automatic logic [4:0] val_code(input logic [3:0] v);
        return (v > 4'd4) ? C_DASH : {1'b0, v};
    endfunction

    assign w_tick = (r_presc == PRESC_LAST);

    always_ff @(posedge clock) begin
        if (!reset) r_state <= ST_ENTRY;
        else        r_state <= w_next_state;
    end

    // w_enter also fires on RESULT->RESULT so a fresh result restarts the hold timer
    always_comb begin
        w_next_state = r_state;
        w_enter      = 1'b0;
        if (bus.new_game) begin
            w_next_state = ST_ENTRY;
            w_enter      = (r_state != ST_ENTRY);
        end else if (bus.result_valid && r_state != ST_WIN) begin
            w_next_state = (bus.bulls == 3'd4) ? ST_WIN : ST_RESULT;
            w_enter      = 1'b1;
        end else if (r_state == ST_RESULT && w_tick && r_ms == RESULT_LAST) begin
            w_next_state = ST_ENTRY;
            w_enter      = 1'b1;
        end
    end

    assign w_latch = !bus.new_game && bus.result_valid && (r_state != ST_WIN);

    always_ff @(posedge clock) begin
        if (!reset || w_enter) begin
            r_presc     <= '0;
            r_ms        <= '0;
            r_blink_off <= 1'b0;
        end else begin
            r_presc <= w_tick ? '0 : r_presc + 1'b1;
            if (w_tick && r_state != ST_ENTRY) begin
                if (r_state == ST_WIN && r_ms == BLINK_LAST) begin
                    r_ms        <= '0;
                    r_blink_off <= ~r_blink_off;
                end else begin
                    r_ms <= r_ms + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_bulls      <= '0;
            r_cows       <= '0;
            r_win_player <= 1'b0;
        end else begin
            if (w_latch) begin
                r_bulls <= bus.bulls;
                r_cows  <= bus.cows;
            end
            if (w_enter && w_next_state == ST_WIN) r_win_player <= bus.player;
        end
    end

    always_comb begin
        bus.busy = (r_state != ST_ENTRY);
        w_d      = {8{BLANK}};
        w_cnt    = (bus.entry_cnt > 3'd4) ? 3'd4 : bus.entry_cnt;
        case (r_state)
            ST_ENTRY: begin
                w_d[7] = {1'b1, C_J, 1'b1};
                w_d[6] = {1'b1, bus.player ? C_2 : C_1, 1'b1};
                // entry i sits at w_d[3-i]; the first unentered slot carries the cursor dot
                for (int unsigned i = 0; i < 4; i++) begin
                    if (i < 32'(w_cnt))
                        w_d[3'(3 - i)] = {1'b1, val_code(bus.entry_digits[4'(4 * (3 - i)) +: 4]), 1'b1};
                    else if (i == 32'(w_cnt))
                        w_d[3'(3 - i)] = {1'b1, C_BLANK, 1'b0};
                end
            end
            ST_RESULT: begin
                w_d[7] = {1'b1, C_B, 1'b1};
                w_d[6] = {1'b1, val_code({1'b0, r_bulls}), 1'b1};
                w_d[5] = {1'b1, C_BLANK, 1'b1};
                w_d[4] = {1'b1, C_C, 1'b1};
                w_d[3] = {1'b1, val_code({1'b0, r_cows}), 1'b1};
            end
            ST_WIN: begin
                w_d[7] = {1'b1, C_J, 1'b1};
                w_d[6] = {1'b1, r_win_player ? C_2 : C_1, 1'b1};
                w_d[5] = {1'b1, C_BLANK, 1'b1};
                w_d[4] = {1'b1, C_BLANK, 1'b1};
                w_d[3] = {1'b1, C_B, 1'b1};
                w_d[2] = {1'b1, C_E, 1'b1};
                w_d[1] = {1'b1, C_S, 1'b1};
                w_d[0] = {1'b1, C_T, 1'b1};
                if (r_blink_off) begin
                    for (int unsigned k = 0; k < 8; k++) w_d[3'(k)][6] = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) r_d <= {8{BLANK}};
        else        r_d <= w_d;
    end

    assign bus.d1 = r_d[0];
    assign bus.d2 = r_d[1];
    assign bus.d3 = r_d[2];
    assign bus.d4 = r_d[3];
    assign bus.d5 = r_d[4];
    assign bus.d6 = r_d[5];
    assign bus.d7 = r_d[6];
    assign bus.d8 = r_d[7];
endmodule

// File: tb/tb_dspl_fmt_ctrl.sv
// Self-checking bench for dspl_fmt_ctrl with short timing parameters; expected
// digit codes are queued with each stimulus and compared once the outputs settle.
module tb_dspl_fmt_ctrl;
    localparam logic [6:0] BLANK = 7'b0100001;
    localparam logic [6:0] CUR   = 7'b1100000;
    localparam logic [6:0] DIG_J = 7'b1001011;
    localparam logic [6:0] DIG_0 = 7'b1000001;
    localparam logic [6:0] DIG_1 = 7'b1000011;
    localparam logic [6:0] DIG_2 = 7'b1000101;
    localparam logic [6:0] DIG_3 = 7'b1000111;
    localparam logic [6:0] DIG_4 = 7'b1001001;
    localparam logic [6:0] DASH  = 7'b1100011;
    localparam logic [6:0] DIG_B = 7'b1010111;
    localparam logic [6:0] DIG_C = 7'b1011001;
    localparam logic [6:0] SPACE = 7'b1100001;
    localparam logic [6:0] DIG_E = 7'b1001111;
    localparam logic [6:0] DIG_S = 7'b1001101;
    localparam logic [6:0] DIG_T = 7'b1010001;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    typedef struct {
        string      tag;
        int         sel;
        logic [6:0] exp;
    } exp_t;
    exp_t sb_q[$];

    dspl_fmt_ctrl_if u_if ();

    dspl_fmt_ctrl #(
        .MS_COUNT (4),
        .RESULT_MS(3),
        .BLINK_MS (2)
    ) u_dut (
        .clock(clock),
        .reset(reset),
        .bus  (u_if.slave)
    );

    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] get_out(input int sel);
        case (sel)
            0:       return {6'b0, u_if.busy};
            1:       return u_if.d1;
            2:       return u_if.d2;
            3:       return u_if.d3;
            4:       return u_if.d4;
            5:       return u_if.d5;
            6:       return u_if.d6;
            7:       return u_if.d7;
            default: return u_if.d8;
        endcase
    endfunction

    task automatic expect_out(input string tag, input int sel, input logic [6:0] exp);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic sb_drain();
        exp_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_val(e.tag, get_out(e.sel), e.exp);
        end
    endtask

    task automatic expect_all_blank(input string tag);
        for (int k = 1; k <= 8; k++) expect_out(tag, k, BLANK);
        expect_out({tag, "_busy"}, 0, 7'd0);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        u_if.player       = 1'b0;
        u_if.entry_cnt    = 3'd0;
        u_if.entry_digits = 16'h0000;
        u_if.result_valid = 1'b0;
        u_if.bulls        = 3'd0;
        u_if.cows         = 3'd0;
        u_if.new_game     = 1'b0;

        // reset
        reset = 1'b0;
        expect_all_blank("rst");
        step(2);
        sb_drain();

        reset = 1'b1;
        expect_out("rel_d8", 8, DIG_J);
        expect_out("rel_d7", 7, DIG_1);
        expect_out("rel_d6", 6, BLANK);
        expect_out("rel_d5", 5, BLANK);
        expect_out("rel_d4", 4, CUR);
        expect_out("rel_d3", 3, BLANK);
        expect_out("rel_d1", 1, BLANK);
        step(1);
        sb_drain();

        // entry display
        u_if.entry_cnt    = 3'd2;
        u_if.entry_digits = 16'h3100;
        expect_out("ent_d4", 4, DIG_3);
        expect_out("ent_d3", 3, DIG_1);
        expect_out("ent_d2", 2, CUR);
        expect_out("ent_d1", 1, BLANK);
        step(1);
        sb_drain();

        u_if.entry_digits = 16'h7100;
        expect_out("ent_dash", 4, DASH);
        step(1);
        sb_drain();

        u_if.entry_cnt    = 3'd5;
        u_if.entry_digits = 16'h0123;
        expect_out("cnt5_d4", 4, DIG_0);
        expect_out("cnt5_d3", 3, DIG_1);
        expect_out("cnt5_d2", 2, DIG_2);
        expect_out("cnt5_d1", 1, DIG_3);
        step(1);
        sb_drain();

        u_if.entry_cnt    = 3'd4;
        u_if.entry_digits = 16'h40F2;
        expect_out("cnt4_d4", 4, DIG_4);
        expect_out("cnt4_d3", 3, DIG_0);
        expect_out("cnt4_d2", 2, DASH);
        expect_out("cnt4_d1", 1, DIG_2);
        step(1);
        sb_drain();

        // result hold, entered at E0
        u_if.result_valid = 1'b1;
        u_if.bulls        = 3'd2;
        u_if.cows         = 3'd1;
        expect_out("res_busy", 0, 7'd1);
        step(1);
        sb_drain();
        u_if.result_valid = 1'b0;
        u_if.bulls        = 3'd0;
        u_if.cows         = 3'd0;
        expect_out("res_d8", 8, DIG_B);
        expect_out("res_d7", 7, DIG_2);
        expect_out("res_d6", 6, SPACE);
        expect_out("res_d5", 5, DIG_C);
        expect_out("res_d4", 4, DIG_1);
        expect_out("res_d3", 3, BLANK);
        expect_out("res_d1", 1, BLANK);
        step(1);
        sb_drain();
        expect_out("hold_e11", 0, 7'd1);
        step(10);
        sb_drain();
        expect_out("hold_e12", 0, 7'd0);
        step(1);
        sb_drain();
        expect_out("back_d8", 8, DIG_J);
        step(1);
        sb_drain();

        // hold restart at cycle 6
        u_if.result_valid = 1'b1;
        u_if.bulls        = 3'd2;
        u_if.cows         = 3'd1;
        step(1);
        u_if.result_valid = 1'b0;
        expect_out("ext_e5", 0, 7'd1);
        step(5);
        sb_drain();
        u_if.result_valid = 1'b1;
        u_if.bulls        = 3'd1;
        u_if.cows         = 3'd6;
        step(1);
        u_if.result_valid = 1'b0;
        u_if.bulls        = 3'd0;
        u_if.cows         = 3'd0;
        expect_out("relatch_d7", 7, DIG_1);
        expect_out("relatch_d4", 4, DASH);
        step(1);
        sb_drain();
        expect_out("ext_e17", 0, 7'd1);
        step(10);
        sb_drain();
        expect_out("ext_e18", 0, 7'd0);
        step(1);
        sb_drain();

        // win banner and blink
        u_if.player       = 1'b1;
        u_if.result_valid = 1'b1;
        u_if.bulls        = 3'd4;
        expect_out("win_busy", 0, 7'd1);
        step(1);
        sb_drain();
        u_if.result_valid = 1'b0;
        u_if.player       = 1'b0;
        expect_out("win_d8", 8, DIG_J);
        expect_out("win_d7", 7, DIG_2);
        expect_out("win_d4", 4, DIG_B);
        expect_out("win_d3", 3, DIG_E);
        expect_out("win_d2", 2, DIG_S);
        expect_out("win_d1", 1, DIG_T);
        step(1);
        sb_drain();
        expect_out("blink_on_e8", 1, DIG_T);
        step(7);
        sb_drain();
        expect_out("blink_off_d1", 1, 7'b0010001);
        expect_out("blink_off_d8", 8, 7'b0001011);
        expect_out("blink_off_d7", 7, 7'b0000101);
        step(1);
        sb_drain();
        u_if.result_valid = 1'b1;
        u_if.bulls        = 3'd2;
        expect_out("win_ign_busy", 0, 7'd1);
        step(1);
        sb_drain();
        u_if.result_valid = 1'b0;
        expect_out("blink_off_e16", 1, 7'b0010001);
        step(6);
        sb_drain();
        expect_out("blink_on_d1", 1, DIG_T);
        expect_out("blink_on_d8", 8, DIG_J);
        expect_out("blink_on_d7", 7, DIG_2);
        step(1);
        sb_drain();

        // reset mid-win
        reset = 1'b0;
        u_if.entry_cnt = 3'd0;
        expect_all_blank("rst_win");
        step(1);
        sb_drain();
        reset = 1'b1;
        expect_out("rst_win_d8", 8, DIG_J);
        expect_out("rst_win_d7", 7, DIG_1);
        expect_out("rst_win_d4", 4, CUR);
        step(1);
        sb_drain();

        // new_game beats result_valid in RESULT
        u_if.result_valid = 1'b1;
        u_if.bulls        = 3'd2;
        u_if.cows         = 3'd1;
        expect_out("ng_res_busy", 0, 7'd1);
        step(1);
        sb_drain();
        u_if.new_game = 1'b1;
        u_if.bulls    = 3'd4;
        expect_out("ng_busy", 0, 7'd0);
        step(1);
        sb_drain();
        u_if.new_game     = 1'b0;
        u_if.result_valid = 1'b0;
        expect_out("ng_d8", 8, DIG_J);
        expect_out("ng_d4", 4, CUR);
        step(1);
        sb_drain();

        // new_game leaves WIN
        u_if.result_valid = 1'b1;
        u_if.bulls        = 3'd4;
        step(1);
        u_if.result_valid = 1'b0;
        u_if.new_game     = 1'b1;
        expect_out("ngw_busy", 0, 7'd0);
        step(1);
        sb_drain();
        u_if.new_game = 1'b0;
        expect_out("ngw_d8", 8, DIG_J);
        expect_out("ngw_d7", 7, DIG_1);
        step(1);
        sb_drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/dspl_fmt_ctrl.md
Name: dspl_fmt_ctrl

Overview:
- Formatter stage directly upstream of the 8-digit multiplexed display driver.
- Converts game status (player, entered guess digits, bulls/cows result, win) into the eight 7-bit digit codes d1..d8 that the driver consumes.
- Owns display timing: timed result hold, blinking win banner, and a cursor dot marking the next entry position.

Parameters:
- MS_COUNT, 100000: clock cycles per 1 ms tick (100 MHz).
- RESULT_MS, 2000: result screen hold time in ms.
- BLINK_MS, 250: win banner half-period in ms (on time = off time).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-low reset
- player  in  1  current player: 0 = J1, 1 = J2
- entry_cnt  in  3  number of guess digits entered, 0..4
- entry_digits  in  16  four nibbles; [15:12] is first entered digit
- result_valid  in  1  one-cycle pulse; bulls/cows are valid this cycle
- bulls  in  3  bulls count
- cows  in  3  cows count
- new_game  in  1  one-cycle pulse; leave RESULT or WIN, go to ENTRY
- busy  out  1  high in RESULT and WIN; game controller must hold input
- d1..d8  out  7 each  digit code to driver; d8 is leftmost

Behaviour:
- Digit code format is {en, code[4:0], dp}:
  - en = 1 lights the digit.
  - code values: 0x00..0x04 = digits 0..4; 05 J; 06 S; 07 E; 08 T; 09 U; 0A P; 0B B; 0C C; 0D L; 0E Y; 0F G; 10 blank; 11 dash.
  - dp = 0 lights the point; dp = 1 turns it off.
- Value-to-digit rule: a value 0..4 maps to code = value; any value > 4 maps to dash (0x11).
- BLANK is defined as 7'b0100001 (disabled, blank code, point off).
- Reset (reset == 0 at posedge):
  - state = ENTRY, busy = 0, all d* = BLANK.
  - Prescaler, ms counter and blink phase are cleared.
- Outputs are registered: d* reflect the state and inputs of the previous cycle (1-cycle latency). busy is combinational from state.
- ms tick: prescaler counts 0..MS_COUNT-1 and asserts tick on MS_COUNT-1. Prescaler and ms counter clear on every state entry, so timing is exact from entry.
- ENTRY:
  - d8 = J (en 1).
  - d7 = digit 1 or 2 (en 1), from player.
  - d6, d5 = BLANK.
  - d4..d1 show nibbles [15:12]..[3:0]. Digit i (0 = d4) has en = 1 only if i < entry_cnt; its code follows the value-to-digit rule.
  - Cursor: if entry_cnt < 4, the digit at position entry_cnt has dp = 0 and en = 1 with blank code. All other dp = 1.
  - entry_cnt > 4 is treated as 4 (no cursor).
  - result_valid with bulls == 4 goes to WIN. result_valid otherwise goes to RESULT. The bulls/cows values are latched on the transition.
- RESULT:
  - d8 = B, d7 = bulls, d6 = blank, d5 = C, d4 = cows, all with en 1. Counts follow the value-to-digit rule.
  - d3..d1 = BLANK.
  - After RESULT_MS ticks, return to ENTRY.
  - A new result_valid restarts the hold and relatches (or goes to WIN if bulls == 4).
- WIN:
  - Banner "J<p> BEST": d8 = J, d7 = player digit, d6 = blank, d5 = blank, d4 = B, d3 = E, d2 = S, d1 = T.
  - Player digit is latched at WIN entry.
  - Blink phase starts ON and toggles every BLINK_MS ticks. When OFF, all en = 0.
  - result_valid is ignored. Stays in WIN until new_game or reset.
- new_game in any state goes to ENTRY. new_game has priority over a simultaneous result_valid.
- Reset asserted mid-RESULT or mid-WIN aborts immediately to the reset values.

Test Plan:
Test parameters: MS_COUNT = 4, RESULT_MS = 3, BLINK_MS = 2.
- Reset check: reset low 2 cycles -> all d* = 7'b0100001, busy = 0. Release with player = 0, entry_cnt = 0 -> d8 = 7'b1001011 (J), d7 = 7'b1000011 (1), d4 = 7'b1100000 (cursor), d3..d1 = BLANK.
- Entry display: entry_cnt = 2, entry_digits = 16'h3100 -> d4 = 7'b1000111, d3 = 7'b1000011, d2 = cursor 7'b1100000, d1 = BLANK. Changing to entry_digits = 16'h7100 -> d4 = dash 7'b1100011.
- Result hold: result_valid with bulls = 2, cows = 1 -> next cycle busy = 1; d7 = 7'b1000101, d4 = 7'b1000011. ENTRY resumes exactly 12 cycles after entry; a second result_valid at cycle 6 extends the hold to 12 cycles from that pulse.
- Win: result_valid with bulls = 4, player = 1 -> WIN, d1 = 7'b1010001 (T). All en bits drop after 8 cycles and return after 16; a later result_valid has no effect.
- new_game vs result_valid: pulse both together in RESULT -> ENTRY, busy = 0 next cycle, no relatch.
- Reset mid-WIN: reset low 1 cycle -> all BLANK, busy = 0; ENTRY display again after release.
